// File: rtl/regfile_write_demux.sv
// regfile_write_demux
//   Write side of the 32-entry integer register file. The write-back address is
//   decoded one-hot and steers i_rd_data into exactly one of x1..x31. x0 is
//   not stored and always reads as zero. All registers are exported as one flat
//   bus for the read-port mux trees.
//
//   Optional feature, enabled by defining REGFILE_SCOREBOARD_EN: a per-register
//   busy scoreboard. Issue sets a destination pending, and write-back clears it.
//
// Parameters
//   DATA_W     width of each architectural register
//   RESET_VAL  reset value of x1..x31
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_rd_wren    write-back enable
//   i_rd_addr    destination register index
//   i_rd_data    write-back data
//   o_wr_onehot  combinational gated decode of i_rd_addr (bit 0 always 0)
//   o_regs       flat register image, register k at [DATA_W*k +: DATA_W]
//   i_sb_set     (scoreboard) mark i_sb_addr pending
//   i_sb_addr    (scoreboard) index to mark pending
//   o_sb_busy    (scoreboard) per-register pending flags (bit 0 always 0)

// Storage cell for one architectural register.
module regfile_reg #(
   parameter int                DATA_W    = 32,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_wen,
   input  logic [DATA_W-1:0] i_d,
   output logic [DATA_W-1:0] o_q
);
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)   o_q <= RESET_VAL;
      else if (i_wen) o_q <= i_d;
   end
endmodule

module regfile_write_demux #(
   parameter int                DATA_W    = 32,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_rd_wren,
   input  logic [4:0]           i_rd_addr,
   input  logic [DATA_W-1:0]    i_rd_data,
   output logic [31:0]          o_wr_onehot,
`ifdef REGFILE_SCOREBOARD_EN
   input  logic                 i_sb_set,
   input  logic [4:0]           i_sb_addr,
   output logic [31:0]          o_sb_busy,
`endif
   output logic [32*DATA_W-1:0] o_regs
);
   logic [31:0][DATA_W-1:0] regs;

   // Bit 0 is never set, so x0 writes are dropped at the decode.
   always_comb begin
      o_wr_onehot = '0;
      for (int k = 1; k < 32; k++)
         o_wr_onehot[k] = i_rd_wren && (i_rd_addr == k[4:0]);
   end

   assign regs[0] = '0;

   for (genvar k = 1; k < 32; k++) begin : g_reg
      regfile_reg #(.DATA_W(DATA_W), .RESET_VAL(RESET_VAL)) u_reg (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .i_wen   (o_wr_onehot[k]),
         .i_d     (i_rd_data),
         .o_q     (regs[k])
      );
   end

   assign o_regs = regs;

`ifdef REGFILE_SCOREBOARD_EN
   logic [31:0] sb_set_onehot;

   always_comb begin
      sb_set_onehot = '0;
      for (int k = 1; k < 32; k++)
         sb_set_onehot[k] = i_sb_set && (i_sb_addr == k[4:0]);
   end

   // A set takes priority over a clear on the same register: the new producer
   // issued this cycle is still in flight after the old one retires.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) o_sb_busy <= '0;
      else          o_sb_busy <= sb_set_onehot | (o_sb_busy & ~o_wr_onehot);
   end
`endif

endmodule
